// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, load funct3 codes and the writeback FSM states.
package rv32i_pkg;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] FENCE  = 7'b0001111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   localparam logic [2:0] LB  = 3'd0;
   localparam logic [2:0] LH  = 3'd1;
   localparam logic [2:0] LW  = 3'd2;
   localparam logic [2:0] LBU = 3'd4;
   localparam logic [2:0] LHU = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_MEM,
      WRITE,
      ACK
   } wb_state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a word-aligned load and extends it;
// also reports whether the funct3/address pair is an illegal (misaligned) load.
module load_align
   import rv32i_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] result,
   output logic        misalign
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr[1] ? word[31:16] : word[15:0];
   end

   // Reserved funct3 codes count as misaligned so they are dropped the same way.
   always_comb begin
      result   = word;
      misalign = 1'b0;
      case (funct3)
         LB:      result = {{24{byte_sel[7]}}, byte_sel};
         LBU:     result = {24'h0, byte_sel};
         LH: begin
            result   = {{16{half_sel[15]}}, half_sel};
            misalign = addr[0];
         end
         LHU: begin
            result   = {16'h0, half_sel};
            misalign = addr[0];
         end
         LW:      misalign = (addr != 2'd0);
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/wb_ctrl.sv
// RV32I writeback controller: captures a retiring instruction, produces the
// register-file write data, issues a one-cycle strobe and waits for the acknowledge.
module wb_ctrl
   import rv32i_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [31:0] inst_in,
   input  logic [31:0] alu_res,
   input  logic [31:0] pc,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   input  logic        wb_update,
   output logic        regwr,
   output logic [31:0] wrdata,
   output logic [31:0] inst,
   output logic        busy,
   output logic        wb_done,
   output logic        err_misalign,
   output logic        err_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   wb_state_t        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [31:0]      wrdata_n, inst_n;
   logic [1:0]       addr_q, addr_n;
   logic             done_n, mis_n, to_n;

   logic [1:0]  la_addr;
   logic [2:0]  la_funct3;
   logic [31:0] la_result;
   logic        la_misalign;

   // In IDLE the aligner screens the incoming instruction; afterwards it
   // works on the captured instruction and address.
   assign la_addr   = (state == IDLE) ? alu_res[1:0]    : addr_q;
   assign la_funct3 = (state == IDLE) ? inst_in[14:12] : inst[14:12];

   load_align u_load_align (
      .word     (mem_rdata),
      .addr     (la_addr),
      .funct3   (la_funct3),
      .result   (la_result),
      .misalign (la_misalign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         wrdata       <= '0;
         inst         <= '0;
         addr_q       <= '0;
         wb_done      <= 1'b0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         wrdata       <= wrdata_n;
         inst         <= inst_n;
         addr_q       <= addr_n;
         wb_done      <= done_n;
         err_misalign <= mis_n;
         err_timeout  <= to_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      wrdata_n = wrdata;
      inst_n   = inst;
      addr_n   = addr_q;
      done_n   = 1'b0;
      mis_n    = 1'b0;
      to_n     = 1'b0;
      case (state)
         IDLE: begin
            if (wb_valid) begin
               inst_n = inst_in;
               addr_n = alu_res[1:0];
               if (inst_in[11:7] == 5'd0) begin
                  done_n = 1'b1;
               end else begin
                  case (inst_in[6:0])
                     LOAD: begin
                        if (la_misalign) begin
                           mis_n  = 1'b1;
                           done_n = 1'b1;
                        end else begin
                           state_n = WAIT_MEM;
                           cnt_n   = '0;
                        end
                     end
                     LUI: begin
                        wrdata_n = {inst_in[31:12], 12'h000};
                        state_n  = WRITE;
                     end
                     JAL, JALR: begin
                        wrdata_n = pc + 32'd4;
                        state_n  = WRITE;
                     end
                     OP, OP_IMM, AUIPC: begin
                        wrdata_n = alu_res;
                        state_n  = WRITE;
                     end
                     default: done_n = 1'b1;
                  endcase
               end
            end
         end
         WAIT_MEM: begin
            if (mem_rvalid) begin
               wrdata_n = la_result;
               state_n  = WRITE;
            end else if (cnt == CNT_LAST) begin
               state_n = IDLE;
               to_n    = 1'b1;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         WRITE: begin
            state_n = ACK;
            cnt_n   = '0;
         end
         ACK: begin
            if (wb_update) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_n = IDLE;
               to_n    = 1'b1;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Strobe and busy come straight from state so a reset kills them at once.
   assign regwr = (state == WRITE);
   assign busy  = (state != IDLE);

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller for the RV32I core; it drives the write side of the register file (`regwr`, `wrdata`, `inst`). It captures a retiring instruction from execute/memory, picks the writeback source, aligns and extends load data, and issues a single-cycle write strobe. It then waits for the register file's `wb_update` acknowledge before reporting completion. Instructions that do not write a register are retired without a strobe, and malformed or stalled loads are flagged.

## Interface
- `TIMEOUT`, 16: maximum cycles spent in WAIT_MEM or ACK before aborting.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_valid`  in  1  one-cycle pulse; instruction ready to retire; sampled only in IDLE.
- `inst_in`  in  32  retiring instruction word.
- `alu_res`  in  32  ALU result (OP, OP-IMM, AUIPC value; load/store address).
- `pc`  in  32  PC of retiring instruction.
- `mem_rdata`  in  32  data-memory read word (word-aligned).
- `mem_rvalid`  in  1  `mem_rdata` valid this cycle.
- `wb_update`  in  1  register-file write acknowledge.
- `regwr`  out  1  register-file write strobe.
- `wrdata`  out  32  register-file write data.
- `inst`  out  32  instruction presented to register file (rd = `inst[11:7]`).
- `busy`  out  1  high whenever state != IDLE.
- `wb_done`  out  1  one-cycle retire pulse.
- `err_misalign`  out  1  one-cycle pulse: misaligned load dropped.
- `err_timeout`  out  1  one-cycle pulse: TIMEOUT expired.

## Operation
- States: IDLE, WAIT_MEM, WRITE, ACK.
- IDLE + `wb_valid`: register `inst_in` to `inst`, and latch `alu_res` and `pc`. Decode `opcode = inst_in[6:0]`:
  - No-write (rd==0, STORE 0100011, BRANCH 1100011, FENCE 0001111, SYSTEM 1110011, unknown opcode): stay IDLE, `wb_done` pulses.
  - LOAD 0000011: misaligned (LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 in {3,6,7}) -> stay IDLE, `err_misalign` pulses and `wb_done` pulses. Otherwise -> WAIT_MEM, counter cleared.
  - LUI: `wrdata = {inst_in[31:12],12'h0}`. JAL/JALR: `wrdata = pc+4` (mod 2^32). OP/OP-IMM/AUIPC: `wrdata = alu_res`. Then -> WRITE.
- WAIT_MEM: on `mem_rvalid`, select the byte/half at addr[1:0] and extend per funct3 (LB/LH sign, LBU/LHU zero, LW passthrough), then -> WRITE. Otherwise increment counter; at TIMEOUT -> IDLE with `err_timeout` and `wb_done` pulses, no write.
- WRITE: `regwr=1` for exactly this cycle, then -> ACK with counter cleared.
- ACK: on `wb_update` -> IDLE with `wb_done` pulse. Otherwise count; at TIMEOUT -> IDLE with `err_timeout` and `wb_done` pulses.
- `wb_valid` while `busy` is ignored. Upstream must hold off until `busy`=0.
- `regwr` is never asserted outside WRITE. `wrdata` and `inst` are stable from WRITE through ACK.

## Timing
- Reset (async, any state): state=IDLE. `regwr`, `wb_done`, `err_*`, `busy` = 0. `wrdata`, `inst` = 0. Counter = 0. Reset during WRITE suppresses the strobe immediately.
- Non-load write: `wb_valid` sampled at edge 0. `regwr` is high in cycle 0–1. The register file writes at edge 1 and `wb_update` rises. ACK sees it at edge 2. `wb_done` is high in cycle 2–3.
- No-write/misaligned: `wb_done` is high the cycle after edge 0.
- Load: `mem_rvalid` sampled at edge k. `regwr` is high in cycle k–k+1. `wb_done` is high in cycle k+2–k+3.
- Timeout: `err_timeout` and `wb_done` assert together, exactly TIMEOUT cycles after entering the waiting state.
- All outputs are registered or decoded from state only. No input-to-output combinational path.

## Structure
- Shared package `rv32i_pkg`: opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM, FENCE, SYSTEM), load funct3 codes (LB=0, LH=1, LW=2, LBU=4, LHU=5), and the `wb_state_t` enum.
- One combinational sub-module `load_align`: (word, addr[1:0], funct3) -> 32-bit extended result plus a misalign flag. It is reused by the misalign check in IDLE.

## Test plan
- ADDI x5 (`inst_in=32'h00A00293`), `alu_res=32'h0000000A` -> `regwr` for 1 cycle with `wrdata=32'h0000000A` and `inst[11:7]=5`; `wb_done` 3 cycles after `wb_valid`.
- LB x6, addr `32'h00000103`, `mem_rdata=32'h80FF1234`, `mem_rvalid` 4 cycles later -> `wrdata=32'hFFFFFF80`. The same case as LBU gives `32'h00000080`. LH at addr 2 gives `32'hFFFF80FF`.
- JAL x1 with `pc=32'hFFFFFFFC` -> `wrdata=32'h00000000` (wrap). LUI x7 imm `20'hABCDE` -> `32'hABCDE000`.
- ADD to rd=0, and SW -> no `regwr`; `wb_done` 1 cycle after `wb_valid`. LW at addr `32'h2` -> `err_misalign` plus `wb_done`, no `regwr`.
- LW with `mem_rvalid` held low -> `err_timeout` after 16 cycles, no `regwr`. `wb_update` held low in ACK -> `err_timeout` after 16 cycles. `wb_valid` pulsed while busy is ignored.
- `rst` asserted in WAIT_MEM and again in WRITE -> outputs go to 0 asynchronously. A following ADDI retires normally.
